vga_fb_ctrl: RTL and testbench

VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_fb_ram.sv | 28 ++
 rtl/vga_fb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vga_fb_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer controller: default 800x600@72
// timing, RGB332 field layout and the 2-bit to 3-bit blue expansion.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BACK    = 64;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 23;

    localparam int RGB_R_W = 3;
    localparam int RGB_G_W = 3;
    localparam int RGB_B_W = 2;
    localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;
    localparam int COLOR_W = 3 * 3;

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [COLOR_W-1:0] color_t;

    // Blue has one bit less than red/green; spread it over the full 3-bit range.
    localparam logic [2:0] BLUE_LUT [4] = '{3'b000, 3'b010, 3'b101, 3'b111};

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic vblank;
        logic frame_start;
    } timing_t;

    // RGB332 byte -> {blue, green, red}, 3 bits each.
    function automatic color_t expand_rgb332(input pix_t d);
        return {BLUE_LUT[d[0 +: RGB_B_W]], d[RGB_B_W +: RGB_G_W], d[PIX_W-1 -: RGB_R_W]};
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: write port A, registered read port B
// (one cycle latency). Contents are never reset.
module vga_fb_ram #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Independent write and read ports; a same-address read returns old data.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_q[a_addr] <= a_data;
        end
        rd_data_q <= mem_q[b_addr];
    end

    assign b_data = rd_data_q;

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with scaled framebuffer scan-out and a write port.
// Three-stage pipeline: counters/address, RAM data, registered outputs.
// Optional colour-bar generator is built only when VGA_TEST_PATTERN_EN is
// defined; otherwise test_mode is ignored.
module vga_fb_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = DEF_H_VISIBLE,
    parameter int H_FRONT      = DEF_H_FRONT,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BACK       = DEF_H_BACK,
    parameter int V_VISIBLE    = DEF_V_VISIBLE,
    parameter int V_FRONT      = DEF_V_FRONT,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BACK       = DEF_V_BACK,
    parameter bit SYNC_POL     = 1'b1,
    parameter int SCALE_SHIFT  = 1,
    parameter int STRIDE_SHIFT = 9,
    parameter int FB_ADDR_W    = 18,
    parameter int FB_BASE      = 'h2000,
    parameter int FB_DEPTH     = 'h30000
) (
    input  logic                 clk50M,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    output logic                 wr_ack,
    output logic                 wr_err,
    input  logic                 test_mode,
    output logic [8:0]           color_out,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 vblank,
    output logic                 frame_start
);

    localparam int H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W     = $clog2(H_WHOLE + 1);
    localparam int V_W     = $clog2(V_WHOLE + 1);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_WHOLE - 1);
    localparam logic [H_W-1:0] H_VIS_T  = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_WHOLE - 1);
    localparam logic [V_W-1:0] V_VIS_T  = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [FB_ADDR_W-1:0] FB_BASE_T  = FB_ADDR_W'(FB_BASE);
    localparam logic [31:0]          FB_DEPTH_U = 32'(FB_DEPTH);

    localparam timing_t TIM_RST = '{hsync: !SYNC_POL, vsync: !SYNC_POL,
                                    de: 1'b0, vblank: 1'b0, frame_start: 1'b0};

    logic [H_W-1:0]       h_q, h_d;
    logic [V_W-1:0]       v_q, v_d;
    logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    timing_t              tim0;
    timing_t              tim_s1_q, tim_s1_d;
    timing_t              tim_s2_q, tim_s2_d;
    color_t               color_q, color_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 wr_err_q, wr_err_d;
    logic                 visible;
    logic                 wr_ok;
    logic [FB_ADDR_W-1:0] wr_phys;
    pix_t                 rd_data;
    pix_t                 pix_s1;

    // Stage 0: raster counters, sync decode and held read address.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        visible          = (h_q < H_VIS_T) && (v_q < V_VIS_T);
        tim0.hsync       = (h_q >= HS_START && h_q < HS_END) ? SYNC_POL : !SYNC_POL;
        tim0.vsync       = (v_q >= VS_START && v_q < VS_END) ? SYNC_POL : !SYNC_POL;
        tim0.de          = visible;
        tim0.vblank      = (v_q >= V_VIS_T);
        tim0.frame_start = (h_q == '0) && (v_q == '0);
        rd_addr_d        = rd_addr_q;
        if (visible) begin
            rd_addr_d = FB_BASE_T
                      + (FB_ADDR_W'(v_q >> SCALE_SHIFT) << STRIDE_SHIFT)
                      + FB_ADDR_W'(h_q >> SCALE_SHIFT);
        end
    end

    // Write acceptance: in-range writes store now and acknowledge next cycle.
    always_comb begin
        wr_ok    = wr_en && (32'(wr_addr) < FB_DEPTH_U);
        wr_phys  = FB_BASE_T + wr_addr;
        wr_ack_d = wr_ok;
        wr_err_d = wr_en && !wr_ok;
    end

    // RAM read address comes straight from stage 0 so data lands in stage 1.
    vga_fb_ram #(
        .ADDR_W (FB_ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk    (clk50M),
        .a_we   (wr_ok),
        .a_addr (wr_phys),
        .a_data (wr_data),
        .b_addr (rd_addr_d),
        .b_data (rd_data)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int             BAR_W   = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
    localparam logic [H_W-1:0] BAR_W_T = H_W'(BAR_W);

    logic tm_s1_q, tm_s1_d;
    pix_t pat_s1_q, pat_s1_d;

    // Colour-bar value is produced in stage 0 to match the RAM latency.
    always_comb begin
        tm_s1_d  = test_mode;
        pat_s1_d = pix_t'(h_q / BAR_W_T) * pix_t'(36);
    end

    // Stage 1 registers for the pattern path.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tm_s1_q  <= 1'b0;
            pat_s1_q <= '0;
        end else begin
            tm_s1_q  <= tm_s1_d;
            pat_s1_q <= pat_s1_d;
        end
    end

    assign pix_s1 = tm_s1_q ? pat_s1_q : rd_data;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix_s1           = rd_data;
`endif

    // Stage 1 -> stage 2: colour expansion, blanked outside the active area.
    always_comb begin
        tim_s1_d = tim0;
        tim_s2_d = tim_s1_q;
        color_d  = tim_s1_q.de ? expand_rgb332(pix_s1) : '0;
    end

    // All pipeline and status flops; reset holds the raster at (0,0).
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            rd_addr_q <= '0;
            tim_s1_q  <= TIM_RST;
            tim_s2_q  <= TIM_RST;
            color_q   <= '0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            rd_addr_q <= rd_addr_d;
            tim_s1_q  <= tim_s1_d;
            tim_s2_q  <= tim_s2_d;
            color_q   <= color_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign color_out   = color_q;
    assign hsync       = tim_s2_q.hsync;
    assign vsync       = tim_s2_q.vsync;
    assign de          = tim_s2_q.de;
    assign vblank      = tim_s2_q.vblank;
    assign frame_start = tim_s2_q.frame_start;
    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Self-checking bench for vga_fb_ctrl on a reduced 16x8 raster
// (24 clocks/line, 12 lines/frame, 2x scaling, stride 8, negative sync).
module tb_vga_fb_ctrl;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HW = HV + HF + HS + HB;
    localparam int VW = VV + VF + VS + VB;
    localparam int FRAME = HW * VW;
    localparam int BASE  = 'h20;
    localparam int DEPTH = 'h40;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_BUILT = 1'b1;
`else
    localparam bit PAT_BUILT = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] color;
        logic       hs;
        logic       vs;
        logic       de;
        logic       vb;
        logic       fs;
    } outs_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       ack;
        logic       err;
    } wvec_t;

    typedef struct {
        int unsigned due;
        logic        ack;
        logic        err;
    } ackexp_t;

    localparam outs_t RST = '{color: 9'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, vb: 1'b0, fs: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack, wr_err;
    logic       test_mode;
    logic [8:0] color_out;
    logic       hsync, vsync, de, vblank, frame_start;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    logic [7:0]  shadow [256];
    ackexp_t     aq [$];
    wvec_t       wtab [36];

    vga_fb_ctrl #(
        .H_VISIBLE    (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE    (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL     (1'b0),
        .SCALE_SHIFT  (1),
        .STRIDE_SHIFT (3),
        .FB_ADDR_W    (8),
        .FB_BASE      (BASE),
        .FB_DEPTH     (DEPTH)
    ) dut (
        .clk50M      (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .test_mode   (test_mode),
        .color_out   (color_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] blue_of(input logic [1:0] b);
        case (b)
            2'b00:   return 3'b000;
            2'b01:   return 3'b010;
            2'b10:   return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    // Expected outputs for raster position k counted from reset release.
    function automatic outs_t expect_at(input int k, input bit tm);
        outs_t      o;
        int         h, v;
        logic [7:0] d, idx;
        h   = k % HW;
        v   = (k / HW) % VW;
        idx = 8'(BASE + ((v >> 1) << 3) + (h >> 1));
        d   = (tm && PAT_BUILT) ? 8'((h / (HV / 8)) * 36) : shadow[idx];
        o.de    = (h < HV) && (v < VV);
        o.color = o.de ? {blue_of(d[1:0]), d[4:2], d[7:5]} : 9'h000;
        o.hs    = !(h >= HV + HF && h < HV + HF + HS);
        o.vs    = !(v >= VV + VF && v < VV + VF + VS);
        o.vb    = (v >= VV);
        o.fs    = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic outs_t sample();
        return '{color: color_out, hs: hsync, vs: vsync, de: de, vb: vblank, fs: frame_start};
    endfunction

    // Write-response monitor: pops the scoreboard when a response is due.
    always @(negedge clk) begin
        ackexp_t e;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            e = aq.pop_front();
            chk("wr_resp", 32'({wr_ack, wr_err}), 32'({e.ack, e.err}));
        end else if (wr_ack || wr_err) begin
            chk("wr_spurious", 32'({wr_ack, wr_err}), 32'h0);
        end
    end

    // Release reset at the next falling edge and score every output cycle.
    task automatic run_pix(input int ncyc, input bit tm);
        outs_t q [$];
        int    pos [$];
        int    p, hs_low, vs_low;
        outs_t e;
        hs_low = 0;
        vs_low = 0;
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(RST);
        pos.push_back(-1);
        q.push_back(expect_at(0, tm));
        pos.push_back(0);
        for (int j = 1; j <= ncyc; j++) begin
            @(negedge clk);
            e = q.pop_front();
            p = pos.pop_front();
            chk($sformatf("pix[k=%0d]", p), 32'(sample()), 32'(e));
            if (p >= 0 && p < FRAME) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
            end
            q.push_back(expect_at(j, tm));
            pos.push_back(j);
        end
        if (ncyc > FRAME + 1) begin
            chk("hsync_low_per_frame", 32'(hs_low), 32'(HS * VW));
            chk("vsync_low_per_frame", 32'(vs_low), 32'(VS * HW));
        end
    endtask

    initial begin
        int waited;

        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        for (int i = 0; i < 32; i++) begin
            wtab[i] = '{addr: 8'(i), data: (i == 0) ? 8'hE0 : 8'(i * 53 + 7), ack: 1'b1, err: 1'b0};
        end
        wtab[32] = '{addr: 8'h40, data: 8'h5A, ack: 1'b0, err: 1'b1};
        wtab[33] = '{addr: 8'h3F, data: 8'hC3, ack: 1'b1, err: 1'b0};
        wtab[34] = '{addr: 8'hFF, data: 8'h11, ack: 1'b0, err: 1'b1};
        wtab[35] = '{addr: 8'h05, data: 8'h3C, ack: 1'b1, err: 1'b0};

        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        test_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(sample()), 32'(RST));
        chk("reset_wr", 32'({wr_ack, wr_err}), 32'h0);

        // Back-to-back writes, one per cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            wr_en   = 1'b1;
            wr_addr = wtab[i].addr;
            wr_data = wtab[i].data;
            aq.push_back('{due: cyc + 1, ack: wtab[i].ack, err: wtab[i].err});
            if (wtab[i].ack) shadow[8'(BASE + int'(wtab[i].addr))] = wtab[i].data;
            @(negedge clk);
        end
        wr_en = 1'b0;
        waited = 0;
        while (aq.size() > 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        chk("wr_resp_drained", 32'(aq.size()), 32'h0);
        aq.delete();

        // First pixels after release: two cycles of latency, then red 0xE0.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_first_px", 32'(sample()), 32'(RST));
        @(negedge clk);
        chk("px00_color", 32'(color_out), 32'h007);
        chk("px00_de_fs", 32'({de, frame_start}), 32'b11);
        @(negedge clk);
        chk("px10_color", 32'(color_out), 32'h007);
        chk("px10_fs", 32'(frame_start), 32'h0);

        // Two full frames plus part of a third, then reset mid-frame at v=6.
        rst_n = 1'b0;
        run_pix(2 * FRAME + 6 * HW + 5, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'(sample()), 32'(RST));
        run_pix(FRAME + 12, 1'b0);

        // Pattern request: colour bars when built in, framebuffer otherwise.
        rst_n     = 1'b0;
        test_mode = 1'b1;
        run_pix(FRAME + 12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
